tug_war_game_ctrl: RTL and testbench
====================================

// Module: tug_war_game_ctrl
// PURPOSE
//   Round/match sequencer for the tug-of-war light playfield (chain of light cells
//   with last/edge cells at each end). Turns raw player button levels into
//   one-cycle step commands for the field and detects a round win when the edge
//   light is pushed off. Keeps per-player scores, drives the field reset between
//   rounds, and ends the match when a player reaches SCORE_MAX.
// PARAMETERS
//   SCORE_W   3   width of each score counter
//   SCORE_MAX 7   round wins needed to take the match (1..2**SCORE_W-1)
//   HOLD_CYC  4   cycles the round winner is displayed before field restart (>=1)
//   RST_CYC   2   cycles field_rst is held high to re-centre the field (>=1)
// PORTS
//   clk        in   1        system clock; all state changes on posedge
//   Reset      in   1        synchronous, active-high reset
//   L_btn      in   1        left player button, already synchronised, level
//   R_btn      in   1        right player button, already synchronised, level
//   edge_left  in   1        leftmost field light is lit
//   edge_right in   1        rightmost field light is lit
//   step_left  out  1        1-cycle pulse: field shifts light one place left
//   step_right out  1        1-cycle pulse: field shifts light one place right
//   field_rst  out  1        high: field re-centres (drives light cells' reset/set)
//   l_score    out  SCORE_W  left player round wins
//   r_score    out  SCORE_W  right player round wins
//   winner     out  2        2'b10 left won, 2'b01 right won, 2'b00 none
//   game_over  out  1        match finished; held until Reset
// BEHAVIOUR
//   - All outputs registered. Reset at edge: state=RESTART, cnt=0, scores=0,
//     winner=00, game_over=0, step_*=0, field_rst=1; btn_q regs=1.
//   - Press detect: lp = L_btn & ~Lq, rp = R_btn & ~Rq; Lq/Rq follow buttons every
//     cycle in every state. btn_q reset to 1: a button held through Reset counts
//     only after release and re-press. Holding a button gives exactly one press.
//   - States: RESTART -> PLAY -> ROUND_WON -> (RESTART | MATCH_OVER).
//   - RESTART: field_rst=1 for RST_CYC cycles (cnt counts), winner=00, then PLAY.
//     Presses ignored.
//   - PLAY, edge where exactly one press is seen:
//     lp & ~edge_left  -> step_left=1 next cycle only (latency 1 cycle).
//     rp & ~edge_right -> step_right=1 next cycle only.
//     lp & edge_left   -> round win left: l_score+1, winner=10, go ROUND_WON;
//                         no step pulse. Right side symmetric (r_score, winner=01).
//   - lp & rp same edge: cancel; no step, no win, no score change.
//   - edge_left & edge_right both high (field fault): wins suppressed, steps
//     still issued.
//   - ROUND_WON: winner held for HOLD_CYC cycles, then if the winning score ==
//     SCORE_MAX -> MATCH_OVER, else RESTART. Presses ignored.
//   - MATCH_OVER: game_over=1, winner and scores frozen, field_rst=0, no steps;
//     exits only via Reset.
//   - Scores never wrap: increment only in PLAY, and SCORE_MAX forces MATCH_OVER.
//   - step_left/step_right never high together; no step in any non-PLAY state.
//   - Reset mid-round or mid-hold: full reset at that edge; pending step dropped.
// TESTING
//   1. Reset 3 cycles then release, buttons 0 -> field_rst=1 for 2 cycles,
//      then PLAY; scores 0, winner 00.
//   2. PLAY, L_btn held 5 cycles, edges 0 -> exactly one step_left pulse,
//      1 cycle after the first high sample.
//   3. L_btn and R_btn rise on the same edge -> no step, scores unchanged.
//   4. edge_left=1, L press -> l_score 0->1, winner=10 for 4 cycles, then field_rst
//      for 2 cycles, then PLAY with winner=00; no step_left pulse.
//   5. Right player wins 7 rounds -> r_score=7, game_over=1, presses ignored;
//      Reset -> all cleared.
//   6. L_btn held across Reset release -> no step until release and re-press;
//      Reset during ROUND_WON -> scores 0, RESTART.

Source files
------------

// File: rtl/tug_war_game_ctrl.sv
// Round/match sequencer for the tug-of-war light field: turns button levels into
// one-cycle step pulses, detects round wins at the field edges and keeps match score.
module tug_war_game_ctrl #(
    parameter int SCORE_W   = 3,
    parameter int SCORE_MAX = 7,
    parameter int HOLD_CYC  = 4,
    parameter int RST_CYC   = 2
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               L_btn,
    input  logic               R_btn,
    input  logic               edge_left,
    input  logic               edge_right,
    output logic               step_left,
    output logic               step_right,
    output logic               field_rst,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic [1:0]         winner,
    output logic               game_over
);

    localparam int CNT_MAX = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RESTART    = 2'd0,
        ST_PLAY       = 2'd1,
        ST_ROUND_WON  = 2'd2,
        ST_MATCH_OVER = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [SCORE_W-1:0] l_score_r, l_score_s;
    logic [SCORE_W-1:0] r_score_r, r_score_s;
    logic [1:0]         winner_r, winner_s;
    logic               game_over_r, game_over_s;
    logic               step_left_r, step_left_s;
    logic               step_right_r, step_right_s;
    logic               field_rst_r, field_rst_s;
    logic               lq_r, rq_r;

    logic               lp_s, rp_s;
    logic               win_l_s, win_r_s;
    logic               step_l_s, step_r_s;
    logic [SCORE_W-1:0] won_score_s;

    // Rising-edge press detect; a simultaneous press on both sides cancels out.
    // With both edges lit the field is faulty, so wins are suppressed but steps still go out.
    assign lp_s        = L_btn & ~lq_r;
    assign rp_s        = R_btn & ~rq_r;
    assign win_l_s     = lp_s & ~rp_s & edge_left & ~edge_right;
    assign win_r_s     = rp_s & ~lp_s & edge_right & ~edge_left;
    assign step_l_s    = lp_s & ~rp_s & ~win_l_s;
    assign step_r_s    = rp_s & ~lp_s & ~win_r_s;
    assign won_score_s = (winner_r == 2'b10) ? l_score_r : r_score_r;

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        l_score_s    = l_score_r;
        r_score_s    = r_score_r;
        winner_s     = winner_r;
        game_over_s  = game_over_r;
        step_left_s  = 1'b0;
        step_right_s = 1'b0;
        field_rst_s  = 1'b0;
        case (state_r)
            ST_RESTART: begin
                winner_s = 2'b00;
                if (cnt_r == CNT_W'(RST_CYC - 1)) begin
                    state_s     = ST_PLAY;
                    cnt_s       = '0;
                    field_rst_s = 1'b0;
                end else begin
                    cnt_s       = cnt_r + CNT_W'(1);
                    field_rst_s = 1'b1;
                end
            end
            ST_PLAY: begin
                if (win_l_s) begin
                    l_score_s = l_score_r + SCORE_W'(1);
                    winner_s  = 2'b10;
                    state_s   = ST_ROUND_WON;
                    cnt_s     = '0;
                end else if (win_r_s) begin
                    r_score_s = r_score_r + SCORE_W'(1);
                    winner_s  = 2'b01;
                    state_s   = ST_ROUND_WON;
                    cnt_s     = '0;
                end else begin
                    step_left_s  = step_l_s;
                    step_right_s = step_r_s;
                end
            end
            ST_ROUND_WON: begin
                if (cnt_r == CNT_W'(HOLD_CYC - 1)) begin
                    cnt_s = '0;
                    if (won_score_s == SCORE_W'(SCORE_MAX)) begin
                        state_s     = ST_MATCH_OVER;
                        game_over_s = 1'b1;
                    end else begin
                        state_s     = ST_RESTART;
                        winner_s    = 2'b00;
                        field_rst_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_MATCH_OVER: begin
                game_over_s = 1'b1;
            end
            default: begin
                state_s     = ST_RESTART;
                cnt_s       = '0;
                field_rst_s = 1'b1;
            end
        endcase
    end

    // State, counters, scores, output registers and button history.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r      <= ST_RESTART;
            cnt_r        <= '0;
            l_score_r    <= '0;
            r_score_r    <= '0;
            winner_r     <= 2'b00;
            game_over_r  <= 1'b0;
            step_left_r  <= 1'b0;
            step_right_r <= 1'b0;
            field_rst_r  <= 1'b1;
            lq_r         <= 1'b1;
            rq_r         <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            l_score_r    <= l_score_s;
            r_score_r    <= r_score_s;
            winner_r     <= winner_s;
            game_over_r  <= game_over_s;
            step_left_r  <= step_left_s;
            step_right_r <= step_right_s;
            field_rst_r  <= field_rst_s;
            lq_r         <= L_btn;
            rq_r         <= R_btn;
        end
    end

    assign step_left  = step_left_r;
    assign step_right = step_right_r;
    assign field_rst  = field_rst_r;
    assign l_score    = l_score_r;
    assign r_score    = r_score_r;
    assign winner     = winner_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_tug_war_game_ctrl.sv
// Self-checking bench: directed scenarios plus random play against a
// countdown-based reference model of the round/match rules.
module tb_tug_war_game_ctrl;

    localparam int SCORE_W   = 3;
    localparam int SCORE_MAX = 7;
    localparam int HOLD_CYC  = 4;
    localparam int RST_CYC   = 2;

    logic               clk = 1'b0;
    logic               Reset, L_btn, R_btn, edge_left, edge_right;
    logic               step_left, step_right, field_rst, game_over;
    logic [SCORE_W-1:0] l_score, r_score;
    logic [1:0]         winner;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    // reference model state
    int       m_rst_left, m_hold_left, m_lscore, m_rscore;
    bit       m_over, m_step_l, m_step_r, m_field_rst, m_prev_l, m_prev_r;
    bit [1:0] m_winner;

    tug_war_game_ctrl #(
        .SCORE_W(SCORE_W), .SCORE_MAX(SCORE_MAX), .HOLD_CYC(HOLD_CYC), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk), .Reset(Reset), .L_btn(L_btn), .R_btn(R_btn),
        .edge_left(edge_left), .edge_right(edge_right),
        .step_left(step_left), .step_right(step_right), .field_rst(field_rst),
        .l_score(l_score), .r_score(r_score), .winner(winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        bit lp, rp;
        if (Reset) begin
            m_rst_left = RST_CYC; m_hold_left = 0; m_over = 0;
            m_lscore = 0; m_rscore = 0; m_winner = 2'b00;
            m_step_l = 0; m_step_r = 0; m_prev_l = 1; m_prev_r = 1;
        end else begin
            lp = L_btn && !m_prev_l;
            rp = R_btn && !m_prev_r;
            m_prev_l = L_btn; m_prev_r = R_btn;
            m_step_l = 0; m_step_r = 0;
            if (m_over) begin
                // frozen until Reset
            end else if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    if (((m_winner == 2'b10) ? m_lscore : m_rscore) == SCORE_MAX) m_over = 1;
                    else begin
                        m_rst_left = RST_CYC;
                        m_winner = 2'b00;
                    end
                end
            end else if (m_rst_left > 0) begin
                m_rst_left--;
                m_winner = 2'b00;
            end else if (lp && !rp) begin
                if (edge_left && !edge_right) begin
                    m_lscore++; m_winner = 2'b10; m_hold_left = HOLD_CYC;
                end else m_step_l = 1;
            end else if (rp && !lp) begin
                if (edge_right && !edge_left) begin
                    m_rscore++; m_winner = 2'b01; m_hold_left = HOLD_CYC;
                end else m_step_r = 1;
            end
        end
        m_field_rst = !m_over && (m_hold_left == 0) && (m_rst_left > 0);
    endtask

    task automatic cyc(input bit l, input bit r, input bit el, input bit er, input bit rst);
        L_btn = l; R_btn = r; edge_left = el; edge_right = er; Reset = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("step_left",  {31'd0, step_left},  {31'd0, m_step_l});
        check_val("step_right", {31'd0, step_right}, {31'd0, m_step_r});
        check_val("field_rst",  {31'd0, field_rst},  {31'd0, m_field_rst});
        check_val("l_score",    {29'd0, l_score},    m_lscore);
        check_val("r_score",    {29'd0, r_score},    m_rscore);
        check_val("winner",     {30'd0, winner},     {30'd0, m_winner});
        check_val("game_over",  {31'd0, game_over},  {31'd0, m_over});
    endtask

    initial begin
        int cnt;
        bit l, r;
        // 1: reset then restart phase
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t1_rst_field", {31'd0, field_rst}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t1_restart_field", {31'd0, field_rst}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t1_play_field", {31'd0, field_rst}, 32'd0);
        // 2: held left button gives one step
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(i < 5, 1'b0, 1'b0, 1'b0, 1'b0);
            if (step_left) cnt++;
        end
        check_val("t2_step_pulses", cnt, 32'd1);
        // 3: simultaneous presses cancel
        cnt = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (step_left || step_right) cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (step_left || step_right) cnt++;
        check_val("t3_cancel_steps", cnt, 32'd0);
        // 4: left wins a round
        cnt = 0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("t4_l_score", {29'd0, l_score}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (winner == 2'b10) cnt++;
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_val("t4_winner_cycles", cnt, HOLD_CYC);
        check_val("t4_back_in_play", {30'd0, winner, field_rst}, 32'd0);
        // 5: right wins the match
        for (int i = 0; i < 300 && !game_over; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        check_val("t5_game_over", {31'd0, game_over}, 32'd1);
        check_val("t5_r_score", {29'd0, r_score}, SCORE_MAX);
        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t5_cleared", {23'd0, game_over, l_score, r_score, winner}, 32'd0);
        // 6: button held across reset, then reset during round hold
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (step_left) cnt++;
        end
        check_val("t6_held_no_step", cnt, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6_repress_step", {31'd0, step_left}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t6_reset_in_hold", {28'd0, l_score, field_rst}, 32'd1);
        // fault: both edges lit, steps instead of wins
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("fault_step", {30'd0, l_score, step_left}, 32'd0);
        // random play
        l = 0; r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) l = ~l;
            if ($urandom_range(0, 2) == 0) r = ~r;
            cyc(l, r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 399) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
